// File: rtl/ahb_rr_arbiter4.sv
// Four-master AHB arbiter: round-robin grant, lock and burst holding with bounded tenure,
// RETRY/SPLIT re-arbitration. All outputs are registered and advance only when hready=1.
module ahb_rr_arbiter4 #(
    parameter int unsigned DEFAULT_MASTER = 0,
    parameter int unsigned MAX_HOLD       = 16
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic [3:0] hbusreq,
    input  logic [3:0] hlock,
    input  logic [1:0] htrans,
    input  logic       hready,
    input  logic [1:0] hresp,
    output logic [3:0] hgrant,
    output logic [1:0] hmaster,
    output logic [1:0] hmaster_data,
    output logic       hmastlock
);

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        RSP_OKAY  = 2'b00,
        RSP_ERROR = 2'b01,
        RSP_RETRY = 2'b10,
        RSP_SPLIT = 2'b11
    } hresp_e;

    localparam logic [1:0] DEF_IDX    = 2'(DEFAULT_MASTER);
    localparam logic [3:0] DEF_GRANT  = 4'b0001 << DEF_IDX;
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    htrans_e    trans;
    hresp_e     resp;
    logic [1:0] rr_ptr;
    logic [7:0] hold_cnt;
    logic       retry_pend;

    logic [1:0] grant_idx;
    logic [1:0] base;
    logic [3:0] req_rot;
    logic [1:0] offset;
    logic [1:0] winner;
    logic       under_limit;
    logic       hold;

    logic [3:0] hgrant_nxt;
    logic [1:0] rr_ptr_nxt;
    logic [7:0] hold_cnt_nxt;
    logic       hmastlock_nxt;

    assign trans = htrans_e'(htrans);
    assign resp  = hresp_e'(hresp);

    // Index of the current one-hot grant; this master becomes the next address-phase owner.
    always_comb begin
        grant_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (hgrant[i]) grant_idx = 2'(i);
        end
    end

    assign under_limit = (hold_cnt < HOLD_LIMIT);

    // A pending RETRY/SPLIT overrides both lock and burst holding.
    assign hold = ~retry_pend &
                  ((hlock[hmaster] & hbusreq[hmaster]) |
                   (((trans == TR_SEQ) || (trans == TR_BUSY)) & under_limit));

    // Retried master gets lowest priority by searching from just past it.
    assign base = retry_pend ? hmaster_data : rr_ptr;

    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        req_rot = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            req_rot[k] = hbusreq[base + 2'(k + 1)];
        end
        offset = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) offset = 2'(k);
        end
        winner = base + offset + 2'd1;
    end

    always_comb begin
        hgrant_nxt = hgrant;
        rr_ptr_nxt = rr_ptr;
        if (!hold) begin
            if (|hbusreq) begin
                hgrant_nxt = 4'b0001 << winner;
                rr_ptr_nxt = winner;
            end else begin
                hgrant_nxt = DEF_GRANT;
            end
        end

        hmastlock_nxt = hlock[grant_idx] & ~(retry_pend & (grant_idx == hmaster_data));

        hold_cnt_nxt = hold_cnt;
        if (grant_idx != hmaster) begin
            hold_cnt_nxt = 8'd0;
        end else if (((trans == TR_NONSEQ) || (trans == TR_SEQ)) && under_limit) begin
            hold_cnt_nxt = hold_cnt + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            hgrant       <= DEF_GRANT;
            hmaster      <= DEF_IDX;
            hmaster_data <= DEF_IDX;
            hmastlock    <= 1'b0;
            rr_ptr       <= DEF_IDX;
            hold_cnt     <= 8'd0;
            retry_pend   <= 1'b0;
        end else if (hready) begin
            hgrant       <= hgrant_nxt;
            hmaster      <= grant_idx;
            hmaster_data <= hmaster;
            hmastlock    <= hmastlock_nxt;
            rr_ptr       <= rr_ptr_nxt;
            hold_cnt     <= hold_cnt_nxt;
            retry_pend   <= 1'b0;
        end else if ((resp == RSP_RETRY) || (resp == RSP_SPLIT)) begin
            retry_pend   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter4.sv
// Self-checking bench for ahb_rr_arbiter4: hand-derived vector table, directed corner
// sequences and randomized traffic against a behavioural arbitration model.
module tb_ahb_rr_arbiter4;

    localparam int DEF      = 0;
    localparam int MAX_HOLD = 4;

    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic [3:0] hbusreq = 4'b0000;
    logic [3:0] hlock = 4'b0000;
    logic [1:0] htrans = 2'b00;
    logic       hready = 1'b1;
    logic [1:0] hresp = 2'b00;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       hmastlock;

    ahb_rr_arbiter4 #(
        .DEFAULT_MASTER(DEF),
        .MAX_HOLD      (MAX_HOLD)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .hbusreq     (hbusreq),
        .hlock       (hlock),
        .htrans      (htrans),
        .hready      (hready),
        .hresp       (hresp),
        .hgrant      (hgrant),
        .hmaster     (hmaster),
        .hmaster_data(hmaster_data),
        .hmastlock   (hmastlock)
    );

    always #5 hclk = ~hclk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owners kept as plain integers.
    int m_g, m_m, m_d, m_ptr, m_cnt;
    bit m_l, m_rp;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lk;
        logic [1:0] tr;
        logic       rdy;
        logic [1:0] rsp;
        logic [3:0] eg;
        logic [1:0] em;
        logic [1:0] ed;
        logic       el;
    } vec_t;

    vec_t vt[11];

    task automatic check(input string tag, input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h", tag, name, act, exp);
        end
    endtask

    function automatic int rr_pick(input int base, input logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            if (req[(base + k) % 4]) return (base + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_g = DEF; m_m = DEF; m_d = DEF; m_ptr = DEF; m_cnt = 0;
        m_l = 1'b0; m_rp = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic [3:0] lk, input logic [1:0] tr,
                              input logic rdy, input logic [1:0] rsp);
        bit keep;
        bit new_l;
        int w;
        int old_m;
        if (!rdy) begin
            if (rsp == 2'b10 || rsp == 2'b11) m_rp = 1'b1;
            return;
        end
        keep  = !m_rp && ((lk[m_m] && req[m_m]) ||
                          ((tr == 2'b11 || tr == 2'b01) && m_cnt < MAX_HOLD));
        w     = rr_pick(m_rp ? m_d : m_ptr, req);
        new_l = lk[m_g] && !(m_rp && m_g == m_d);
        old_m = m_m;
        m_d   = m_m;
        m_m   = m_g;
        m_l   = new_l;
        if (!keep) begin
            if (w < 0) m_g = DEF;
            else begin
                m_g   = w;
                m_ptr = w;
            end
        end
        if (m_m != old_m) m_cnt = 0;
        else if (tr == 2'b10 || tr == 2'b11) m_cnt = (m_cnt + 1 > MAX_HOLD) ? MAX_HOLD : m_cnt + 1;
        m_rp = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        logic [3:0] g_exp;
        g_exp = 4'(1 << m_g);
        check(tag, "hgrant", hgrant, g_exp);
        check(tag, "hmaster", {2'b00, hmaster}, 4'(m_m));
        check(tag, "hmaster_data", {2'b00, hmaster_data}, 4'(m_d));
        check(tag, "hmastlock", {3'b000, hmastlock}, {3'b000, m_l});
        check(tag, "onehot", {3'b000, $onehot(hgrant)}, 4'b0001);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lk,
                        input logic [1:0] tr, input logic rdy, input logic [1:0] rsp);
        hbusreq = req; hlock = lk; htrans = tr; hready = rdy; hresp = rsp;
        @(posedge hclk);
        model_step(req, lk, tr, rdy, rsp);
        #1;
        compare_all(tag);
        @(negedge hclk);
    endtask

    task automatic do_reset(input string tag);
        hresetn = 1'b0;
        hbusreq = 4'b0000; hlock = 4'b0000; htrans = 2'b00; hready = 1'b1; hresp = 2'b00;
        model_reset();
        #2;
        compare_all({tag, "_async"});
        @(negedge hclk);
        compare_all({tag, "_held"});
        hresetn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // req, lock, trans, ready, resp | grant, hmaster, hmaster_data, hmastlock
        vt[0]  = '{4'b0100, 4'b0000, 2'b00, 1'b1, 2'b00, 4'b0100, 2'd0, 2'd0, 1'b0};
        vt[1]  = '{4'b0100, 4'b0000, 2'b00, 1'b1, 2'b00, 4'b0100, 2'd2, 2'd0, 1'b0};
        vt[2]  = '{4'b0100, 4'b0000, 2'b00, 1'b1, 2'b00, 4'b0100, 2'd2, 2'd2, 1'b0};
        vt[3]  = '{4'b0000, 4'b0000, 2'b00, 1'b1, 2'b00, 4'b0001, 2'd2, 2'd2, 1'b0};
        vt[4]  = '{4'b1111, 4'b0000, 2'b10, 1'b1, 2'b00, 4'b1000, 2'd0, 2'd2, 1'b0};
        vt[5]  = '{4'b1111, 4'b0000, 2'b10, 1'b1, 2'b00, 4'b0001, 2'd3, 2'd0, 1'b0};
        vt[6]  = '{4'b1111, 4'b0000, 2'b10, 1'b1, 2'b00, 4'b0010, 2'd0, 2'd3, 1'b0};
        vt[7]  = '{4'b1111, 4'b0000, 2'b10, 1'b1, 2'b00, 4'b0100, 2'd1, 2'd0, 1'b0};
        vt[8]  = '{4'b1111, 4'b0000, 2'b10, 1'b1, 2'b00, 4'b1000, 2'd2, 2'd1, 1'b0};
        vt[9]  = '{4'b1111, 4'b0000, 2'b10, 1'b0, 2'b00, 4'b1000, 2'd2, 2'd1, 1'b0};
        vt[10] = '{4'b1111, 4'b0000, 2'b10, 1'b1, 2'b00, 4'b0001, 2'd3, 2'd2, 1'b0};

        @(negedge hclk);

        // Reset park: idle bus stays with the default master.
        do_reset("rst0");
        for (int i = 0; i < 10; i++) begin
            step("park", 4'b0000, 4'b0000, 2'b00, 1'b1, 2'b00);
            check("park", "grant", hgrant, 4'b0001);
        end

        // Single request pipeline, round robin rotation and a stall, against hand-derived values.
        do_reset("rst1");
        for (int i = 0; i < 11; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tag, vt[i].req, vt[i].lk, vt[i].tr, vt[i].rdy, vt[i].rsp);
            check(tag, "tbl_grant", hgrant, vt[i].eg);
            check(tag, "tbl_master", {2'b00, hmaster}, {2'b00, vt[i].em});
            check(tag, "tbl_data", {2'b00, hmaster_data}, {2'b00, vt[i].ed});
            check(tag, "tbl_lock", {3'b000, hmastlock}, {3'b000, vt[i].el});
        end

        // Burst tenure: master 1 holds through 4 SEQ phases, then master 3 takes over.
        do_reset("rst2");
        step("ten_req", 4'b0010, 4'b0000, 2'b00, 1'b1, 2'b00);
        step("ten_own", 4'b0010, 4'b0000, 2'b00, 1'b1, 2'b00);
        check("ten_own", "owner", {2'b00, hmaster}, 4'd1);
        for (int i = 0; i < MAX_HOLD; i++) begin
            step("ten_seq", 4'b1010, 4'b0000, 2'b11, 1'b1, 2'b00);
            check("ten_seq", "held", hgrant, 4'b0010);
        end
        step("ten_lim", 4'b1010, 4'b0000, 2'b11, 1'b1, 2'b00);
        check("ten_lim", "moved", hgrant, 4'b1000);

        // Locked master 0 with wait states, then unlock.
        do_reset("rst3");
        for (int i = 0; i < 4; i++) begin
            step("lock", 4'b1111, 4'b0001, 2'b10, (i % 2 == 0), 2'b00);
            check("lock", "grant", hgrant, 4'b0001);
            check("lock", "mastlock", {3'b000, hmastlock}, 4'b0001);
        end
        step("unlock", 4'b1111, 4'b0000, 2'b10, 1'b1, 2'b00);
        check("unlock", "grant", hgrant, 4'b0010);

        // RETRY from master 2 overrides its lock and its burst; master 0 is served first.
        do_reset("rst4");
        for (int i = 0; i < 3; i++) step("rt_setup", 4'b0100, 4'b0000, 2'b00, 1'b1, 2'b00);
        check("rt_setup", "data_owner", {2'b00, hmaster_data}, 4'd2);
        step("rt_wait", 4'b0101, 4'b0100, 2'b11, 1'b0, 2'b10);
        check("rt_wait", "grant", hgrant, 4'b0100);
        step("rt_adv", 4'b0101, 4'b0100, 2'b11, 1'b1, 2'b10);
        check("rt_adv", "grant", hgrant, 4'b0001);
        check("rt_adv", "mastlock", {3'b000, hmastlock}, 4'b0000);
        step("rt_m0", 4'b0001, 4'b0001, 2'b00, 1'b1, 2'b00);
        for (int i = 0; i < 2; i++) begin
            step("rt_m0lock", 4'b0101, 4'b0001, 2'b10, 1'b1, 2'b00);
            check("rt_m0lock", "grant", hgrant, 4'b0001);
        end
        step("rt_m2", 4'b0100, 4'b0000, 2'b00, 1'b1, 2'b00);
        check("rt_m2", "grant", hgrant, 4'b0100);

        // Randomized traffic against the model, with a reset in the middle of it.
        do_reset("rst5");
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r_req;
            logic [3:0] r_lk;
            logic [1:0] r_tr;
            logic       r_rdy;
            logic [1:0] r_rsp;
            if (i == 1500) do_reset("rst_mid");
            r_req = 4'($urandom);
            r_lk  = 4'($urandom) & 4'($urandom) & 4'($urandom);
            r_tr  = 2'($urandom);
            r_rdy = ($urandom_range(0, 3) != 0);
            r_rsp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            step("rand", r_req, r_lk, r_tr, r_rdy, r_rsp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
